// File: rtl/plab5_mcore_tdm_defs_pkg.sv
// Shared definitions for the two-domain TDM memory arbiter: message widths,
// domain encodings and FSM states.
package plab5_mcore_tdm_defs;

    // Widths match the vc-mem-msgs 128-bit line request/response formats
    localparam int unsigned REQ_NBITS  = 175;
    localparam int unsigned RESP_NBITS = 143;
    localparam int unsigned CNT_NBITS  = 8;

    typedef enum logic {
        DOM_LOW  = 1'b0,
        DOM_HIGH = 1'b1
    } domain_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/plab5_mcore_tdm_slot_timer.sv
// Free-running slot timer: owner alternates every p_slot_cycles regardless of traffic,
// with issue disabled during the trailing guard cycles of each slot.
module plab5_mcore_tdm_slot_timer
    import plab5_mcore_tdm_defs::*;
#(
    parameter int unsigned p_slot_cycles  = 16,
    parameter int unsigned p_guard_cycles = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [CNT_NBITS-1:0] slot_cnt,
    output logic                 slot_domain,
    output logic                 issue_window
);

    localparam logic [CNT_NBITS-1:0] LastCnt   = CNT_NBITS'(p_slot_cycles - 1);
    localparam logic [CNT_NBITS-1:0] WindowEnd = CNT_NBITS'(p_slot_cycles - p_guard_cycles);

    logic [CNT_NBITS-1:0] cnt_q;
    logic [CNT_NBITS-1:0] cnt_d;
    logic                 dom_q;
    logic                 dom_d;

    always_comb begin
        cnt_d = cnt_q + CNT_NBITS'(1);
        dom_d = dom_q;
        if (cnt_q == LastCnt) begin
            cnt_d = '0;
            dom_d = ~dom_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            dom_q <= DOM_LOW;
        end else begin
            cnt_q <= cnt_d;
            dom_q <= dom_d;
        end
    end

    assign slot_cnt     = cnt_q;
    assign slot_domain  = dom_q;
    assign issue_window = (cnt_q < WindowEnd);

endmodule

// File: rtl/plab5_mcore_tdm_mem_arbiter.sv
// Two-domain TDM memory arbiter: one outstanding request, grant timing fixed by the
// slot schedule, responses steered back to the issuing domain.
module plab5_mcore_tdm_mem_arbiter
    import plab5_mcore_tdm_defs::*;
#(
    parameter int unsigned p_req_nbits    = REQ_NBITS,
    parameter int unsigned p_resp_nbits   = RESP_NBITS,
    parameter int unsigned p_slot_cycles  = 16,
    parameter int unsigned p_guard_cycles = 6
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [p_req_nbits-1:0]  req0_msg,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,

    output logic [p_req_nbits-1:0]  memreq_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic                    memreq_domain,

    input  logic [p_resp_nbits-1:0] memresp_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,

    output logic [p_resp_nbits-1:0] resp0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,

    output logic                    slot_domain
);

    logic [CNT_NBITS-1:0] slot_cnt;
    logic                 issue_window;

    state_e  state_q;
    state_e  state_d;
    domain_e owner_q;
    domain_e owner_d;

    logic issue_ok;
    logic in_wait;
    logic own0;
    logic own1;

    plab5_mcore_tdm_slot_timer #(
        .p_slot_cycles  (p_slot_cycles),
        .p_guard_cycles (p_guard_cycles)
    ) slot_timer (
        .clk          (clk),
        .reset        (reset),
        .slot_cnt     (slot_cnt),
        .slot_domain  (slot_domain),
        .issue_window (issue_window)
    );

    // Gating with reset keeps every handshake low while reset is held
    assign issue_ok = !reset && (state_q == IDLE) && issue_window;
    assign in_wait  = !reset && (state_q == WAIT);
    assign own0     = in_wait && (owner_q == DOM_LOW);
    assign own1     = in_wait && (owner_q == DOM_HIGH);

    always_comb begin
        memreq_domain = slot_domain;
        memreq_msg    = (issue_ok && slot_domain) ? req1_msg : req0_msg;
        memreq_val    = issue_ok && (slot_domain ? req1_val : req0_val);
        req0_rdy      = issue_ok && !slot_domain && memreq_rdy;
        req1_rdy      = issue_ok &&  slot_domain && memreq_rdy;
    end

    // Non-owner response message is zeroed so one domain never observes the other's data
    always_comb begin
        memresp_rdy = (own0 && resp0_rdy) || (own1 && resp1_rdy);
        resp0_val   = own0 && memresp_val;
        resp1_val   = own1 && memresp_val;
        resp0_msg   = own0 ? memresp_msg : '0;
        resp1_msg   = own1 ? memresp_msg : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (memreq_val && memreq_rdy) begin
                    state_d = WAIT;
                    owner_d = domain_e'(slot_domain);
                end
            end
            WAIT: begin
                if (memresp_val && memresp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= DOM_LOW;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: doc/plab5_mcore_tdm_mem_arbiter.md
Name: plab5_mcore_tdm_mem_arbiter

Overview:
- Time-division-multiplexed arbiter that shares one memory request/response port between two security domains: domain 0 (D1, proc0) and domain 1 (D2, proc1).
- Sits between the per-core proc2mem translators and one memory-network port.
- Slot ownership follows a fixed schedule that is independent of traffic, so one domain's activity cannot modulate the other domain's grant timing.
- At most one request is outstanding. Each response is routed back to the domain that issued the matching request.

Parameters:
- p_req_nbits, 175, memory request message width (type+opaque+addr+len+data, 128-bit line).
- p_resp_nbits, 143, memory response message width.
- p_slot_cycles, 16, cycles per domain slot; legal range 2..255.
- p_guard_cycles, 6, cycles at the end of each slot in which no issue is allowed; must be < p_slot_cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0_msg  in  p_req_nbits  domain-0 request.
- req0_val  in  1  domain-0 request valid.
- req0_rdy  out  1  domain-0 request ready.
- req1_msg  in  p_req_nbits  domain-1 request.
- req1_val  in  1  domain-1 request valid.
- req1_rdy  out  1  domain-1 request ready.
- memreq_msg  out  p_req_nbits  shared request message.
- memreq_val  out  1  shared request valid.
- memreq_rdy  in  1  shared request ready.
- memreq_domain  out  1  domain of the current memreq.
- memresp_msg  in  p_resp_nbits  shared response message.
- memresp_val  in  1  shared response valid.
- memresp_rdy  out  1  shared response ready.
- resp0_msg  out  p_resp_nbits  domain-0 response message.
- resp0_val  out  1  domain-0 response valid.
- resp0_rdy  in  1  domain-0 response ready.
- resp1_msg  out  p_resp_nbits  domain-1 response message.
- resp1_val  out  1  domain-1 response valid.
- resp1_rdy  in  1  domain-1 response ready.
- slot_domain  out  1  current slot owner.

Behaviour:
- Reset:
  - slot_cnt=0, slot_domain=0, state=IDLE, owner_q=0.
  - All val/rdy outputs are 0 in the cycle after reset is sampled and while it is held.
  - Reset mid-transaction abandons any outstanding request; a late memresp is then ignored (memresp_rdy=0).
- Slot timer:
  - slot_cnt increments every cycle.
  - At p_slot_cycles-1 it wraps to 0 and slot_domain toggles.
  - The timer runs unconditionally; it never stalls on traffic or on an outstanding request.
- Issue window: issue_ok = (state==IDLE) && (slot_cnt < p_slot_cycles-p_guard_cycles).
- Grant (combinational, X = slot_domain):
  - memreq_msg=reqX_msg; memreq_val=issue_ok && reqX_val.
  - reqX_rdy=issue_ok && memreq_rdy.
  - The non-owner's rdy is 0.
  - memreq_domain=slot_domain.
  - When not issue_ok, memreq_val=0; memreq_msg is don't-care but is driven from req0 to avoid leakage.
- FSM:
  - IDLE: on memreq fire (val&&rdy), go to WAIT and set owner_q=slot_domain.
  - WAIT:
    - memresp_rdy = owner_q ? resp1_rdy : resp0_rdy.
    - resp{owner_q}_val = memresp_val; resp{owner_q}_msg = memresp_msg.
    - The other resp port has val=0.
    - On memresp fire, go to IDLE next cycle. There is no same-cycle re-issue (1-cycle bubble minimum).
  - In IDLE, memresp_rdy=0 and both resp vals are 0; stray responses are stalled, never delivered.
- Slot boundary while in WAIT:
  - The slot still switches.
  - The response is still routed by owner_q.
  - The new owner cannot issue until the FSM returns to IDLE.
  - The guard window is sized so that, with nominal memory latency, this does not occur.
- A request arriving in the guard window is held (rdy=0) until the domain's next slot. It is not dropped.
- Latency: request pass-through is 0 cycles. Response pass-through is 0 cycles, combinational.

Decomposition:
- Shared package/header plab5_mcore_tdm_defs: request/response width macros (reusing the vc-mem-msgs NBITS macros), domain encodings DOM_LOW=0 and DOM_HIGH=1, FSM state encodings IDLE/WAIT.
- One sub-module, plab5_mcore_tdm_slot_timer: slot_cnt, slot_domain, issue-window compare. Parameters p_slot_cycles, p_guard_cycles.
- The top module holds the FSM, owner_q and the muxes.

Test Plan (all with p_slot_cycles=8, p_guard_cycles=3):
- Idle timer: after reset, no traffic -> slot_domain is 0 for cycles 0-7, 1 for cycles 8-15, 0 at cycle 16; all vals 0.
- Domain-0 request: req0_val=1 at cycle 1, memreq_rdy=1 -> memreq_val=1 and memreq_domain=0 at cycle 1. memresp_val=1 at cycle 3 -> resp0_val=1 at cycle 3 with msg equal; resp1_val=0.
- Guard window: req1_val=1 asserted at cycle 13 (slot_cnt=5) -> req1_rdy=0 through cycle 23; fire at cycle 24 (next domain-1 slot, slot_cnt=0).
- Both domains valid continuously, memory 1-cycle latency -> issues alternate by slot only; domain 0 never issues while slot_domain=1; slot boundaries stay identical to the idle case.
- Slot switch while in WAIT: domain-0 issue at cycle 4, memresp withheld until cycle 10 -> resp0_val=1 at cycle 10; domain-1 request issues no earlier than cycle 11.
- Edge cases:
  - Reset asserted during WAIT -> next cycle state=IDLE, slot_cnt=0; a memresp_val arriving afterward sees memresp_rdy=0.
  - Backpressure: resp0_rdy=0 -> memresp_rdy=0 until resp0_rdy=1.
